// File: rtl/exe_issue_reg.sv
// ID->EXE pipeline register: resolves rj/rkd through EXE/MEM/WB bypasses, raises the
// load-use and MEM-not-ready interlocks, and registers ALU operands plus store sideband.
module exe_issue_reg #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,

    input  logic               ds_valid,
    output logic               ds_allowin,
    input  logic [ALUOP_W-1:0] ds_alu_op,
    input  logic [XLEN-1:0]    ds_pc,
    input  logic [XLEN-1:0]    ds_imm,
    input  logic               ds_src1_is_pc,
    input  logic               ds_src2_is_imm,
    input  logic [4:0]         ds_rj_addr,
    input  logic [XLEN-1:0]    ds_rj_value,
    input  logic [4:0]         ds_rkd_addr,
    input  logic [XLEN-1:0]    ds_rkd_value,
    input  logic               ds_rj_used,
    input  logic               ds_rkd_used,
    input  logic [4:0]         ds_dest,
    input  logic               ds_gr_we,
    input  logic               ds_is_load,

    input  logic [XLEN-1:0]    es_alu_result,

    input  logic               ms_valid,
    input  logic               ms_gr_we,
    input  logic [4:0]         ms_dest,
    input  logic [XLEN-1:0]    ms_result,
    input  logic               ms_data_ok,

    input  logic               ws_valid,
    input  logic               ws_gr_we,
    input  logic [4:0]         ws_dest,
    input  logic [XLEN-1:0]    ws_result,

    input  logic               ms_allowin,

    output logic               es_valid,
    output logic               es_to_ms_valid,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [XLEN-1:0]    alu_src1,
    output logic [XLEN-1:0]    alu_src2,
    output logic [XLEN-1:0]    es_pc,
    output logic [4:0]         es_dest,
    output logic               es_gr_we,
    output logic               es_is_load,
    output logic [XLEN-1:0]    es_rkd_value
);

    // Handshake: a transfer happens on a clock edge where the sender's valid and the
    // receiver's allowin are both high; allowin never depends on the sender's valid.
    logic es_allowin;
    logic rj_chk, rkd_chk;
    logic rj_exe_hit, rj_ms_hit, rj_ws_hit;
    logic rkd_exe_hit, rkd_ms_hit, rkd_ws_hit;
    logic ld_use, ms_wait;
    logic [XLEN-1:0] rj_fwd, rkd_fwd;
    logic [XLEN-1:0] src1_nxt, src2_nxt;

    // r0 is hard-wired zero, so it never takes a bypass even if a producer names it.
    assign rj_chk  = ds_rj_used  && (ds_rj_addr  != 5'd0);
    assign rkd_chk = ds_rkd_used && (ds_rkd_addr != 5'd0);

    assign rj_exe_hit  = rj_chk  && es_valid && es_gr_we && (es_dest == ds_rj_addr);
    assign rj_ms_hit   = rj_chk  && ms_valid && ms_gr_we && (ms_dest == ds_rj_addr);
    assign rj_ws_hit   = rj_chk  && ws_valid && ws_gr_we && (ws_dest == ds_rj_addr);
    assign rkd_exe_hit = rkd_chk && es_valid && es_gr_we && (es_dest == ds_rkd_addr);
    assign rkd_ms_hit  = rkd_chk && ms_valid && ms_gr_we && (ms_dest == ds_rkd_addr);
    assign rkd_ws_hit  = rkd_chk && ws_valid && ws_gr_we && (ws_dest == ds_rkd_addr);

    always_comb begin
        rj_fwd = ds_rj_value;
        if (rj_exe_hit)     rj_fwd = es_alu_result;
        else if (rj_ms_hit) rj_fwd = ms_result;
        else if (rj_ws_hit) rj_fwd = ws_result;
    end

    always_comb begin
        rkd_fwd = ds_rkd_value;
        if (rkd_exe_hit)     rkd_fwd = es_alu_result;
        else if (rkd_ms_hit) rkd_fwd = ms_result;
        else if (rkd_ws_hit) rkd_fwd = ws_result;
    end

    assign src1_nxt = ds_src1_is_pc  ? ds_pc  : rj_fwd;
    assign src2_nxt = ds_src2_is_imm ? ds_imm : rkd_fwd;

    // A younger EXE hit shadows MEM, so a pending MEM load only stalls when it is the winner.
    assign ld_use  = (rj_exe_hit || rkd_exe_hit) && es_is_load;
    assign ms_wait = ((rj_ms_hit && !rj_exe_hit) || (rkd_ms_hit && !rkd_exe_hit)) && !ms_data_ok;

    assign es_allowin     = !es_valid || ms_allowin;
    assign ds_allowin     = es_allowin && !ld_use && !ms_wait;
    assign es_to_ms_valid = es_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid     <= 1'b0;
            alu_op       <= '0;
            alu_src1     <= '0;
            alu_src2     <= '0;
            es_pc        <= '0;
            es_dest      <= '0;
            es_gr_we     <= 1'b0;
            es_is_load   <= 1'b0;
            es_rkd_value <= '0;
        end else if (flush) begin
            es_valid <= 1'b0;
        end else if (ds_valid && ds_allowin) begin
            es_valid     <= 1'b1;
            alu_op       <= ds_alu_op;
            alu_src1     <= src1_nxt;
            alu_src2     <= src2_nxt;
            es_pc        <= ds_pc;
            es_dest      <= ds_dest;
            es_gr_we     <= ds_gr_we;
            es_is_load   <= ds_is_load;
            es_rkd_value <= rkd_fwd;
        end else if (es_allowin) begin
            es_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_issue_reg.sv
// Directed bench for exe_issue_reg: capture, bypass priority, interlocks, hold, flush, reset.
module tb_exe_issue_reg;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        ds_valid, ds_allowin;
    logic [11:0] ds_alu_op;
    logic [31:0] ds_pc, ds_imm;
    logic        ds_src1_is_pc, ds_src2_is_imm;
    logic [4:0]  ds_rj_addr, ds_rkd_addr, ds_dest;
    logic [31:0] ds_rj_value, ds_rkd_value;
    logic        ds_rj_used, ds_rkd_used, ds_gr_we, ds_is_load;
    logic [31:0] es_alu_result;
    logic        ms_valid, ms_gr_we, ms_data_ok;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        ws_valid, ws_gr_we;
    logic [4:0]  ws_dest;
    logic [31:0] ws_result;
    logic        ms_allowin;
    logic        es_valid, es_to_ms_valid;
    logic [11:0] alu_op;
    logic [31:0] alu_src1, alu_src2, es_pc, es_rkd_value;
    logic [4:0]  es_dest;
    logic        es_gr_we, es_is_load;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    exe_issue_reg #(.XLEN(32), .ALUOP_W(12)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ds_valid(ds_valid), .ds_allowin(ds_allowin), .ds_alu_op(ds_alu_op),
        .ds_pc(ds_pc), .ds_imm(ds_imm), .ds_src1_is_pc(ds_src1_is_pc),
        .ds_src2_is_imm(ds_src2_is_imm), .ds_rj_addr(ds_rj_addr), .ds_rj_value(ds_rj_value),
        .ds_rkd_addr(ds_rkd_addr), .ds_rkd_value(ds_rkd_value), .ds_rj_used(ds_rj_used),
        .ds_rkd_used(ds_rkd_used), .ds_dest(ds_dest), .ds_gr_we(ds_gr_we),
        .ds_is_load(ds_is_load), .es_alu_result(es_alu_result),
        .ms_valid(ms_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
        .ms_data_ok(ms_data_ok), .ws_valid(ws_valid), .ws_gr_we(ws_gr_we), .ws_dest(ws_dest),
        .ws_result(ws_result), .ms_allowin(ms_allowin), .es_valid(es_valid),
        .es_to_ms_valid(es_to_ms_valid), .alu_op(alu_op), .alu_src1(alu_src1),
        .alu_src2(alu_src2), .es_pc(es_pc), .es_dest(es_dest), .es_gr_we(es_gr_we),
        .es_is_load(es_is_load), .es_rkd_value(es_rkd_value)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bypass();
        ms_valid = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0; ms_data_ok = 1;
        ws_valid = 0; ws_gr_we = 0; ws_dest = 0; ws_result = 0;
    endtask

    // driver: op, pc, imm, src sel, rj, rkd, used flags, dest, we, load
    task automatic drive_instr(input logic [11:0] op, input logic [31:0] pc,
                               input logic [31:0] imm, input logic s1pc, input logic s2imm,
                               input logic [4:0] rj, input logic [31:0] rjv,
                               input logic [4:0] rk, input logic [31:0] rkv,
                               input logic rju, input logic rku,
                               input logic [4:0] dest, input logic we, input logic ld);
        ds_valid = 1; ds_alu_op = op; ds_pc = pc; ds_imm = imm;
        ds_src1_is_pc = s1pc; ds_src2_is_imm = s2imm;
        ds_rj_addr = rj; ds_rj_value = rjv; ds_rkd_addr = rk; ds_rkd_value = rkv;
        ds_rj_used = rju; ds_rkd_used = rku; ds_dest = dest; ds_gr_we = we; ds_is_load = ld;
    endtask

    task automatic drive_idle();
        drive_instr(12'h0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0, 0, 0, 5'd0, 0, 0);
        ds_valid = 0;
    endtask

    initial begin
        reset = 1; flush = 0; ms_allowin = 1; es_alu_result = 0;
        clear_bypass();
        drive_idle();
        step(); step();
        reset = 0;
        #1;
        check("rst_es_valid", {31'b0, es_valid}, 32'h0);
        check("rst_alu_op", {20'b0, alu_op}, 32'h0);
        check("rst_src1", alu_src1, 32'h0);
        check("rst_src2", alu_src2, 32'h0);
        check("rst_pc", es_pc, 32'h0);
        check("rst_rkd", es_rkd_value, 32'h0);
        check("rst_allowin", {31'b0, ds_allowin}, 32'h1);

        // add r4 <- r1 + r2, regfile operands
        drive_instr(12'h001, 32'h1000, 32'h0, 0, 0, 5'd1, 32'h10, 5'd2, 32'h20, 1, 1, 5'd4, 1, 0);
        #1 check("cap_allowin", {31'b0, ds_allowin}, 32'h1);
        step();
        check("cap_valid", {31'b0, es_valid}, 32'h1);
        check("cap_to_ms", {31'b0, es_to_ms_valid}, 32'h1);
        check("cap_op", {20'b0, alu_op}, 32'h001);
        check("cap_src1", alu_src1, 32'h10);
        check("cap_src2", alu_src2, 32'h20);
        check("cap_pc", es_pc, 32'h1000);
        check("cap_dest", {27'b0, es_dest}, 32'd4);

        // add r5 <- r4 + r4 with EXE result 0x30
        es_alu_result = 32'h30;
        drive_instr(12'h001, 32'h1004, 32'h0, 0, 0, 5'd4, 32'hAAAA, 5'd4, 32'hBBBB, 1, 1, 5'd5, 1, 0);
        step();
        check("exe_src1", alu_src1, 32'h30);
        check("exe_src2", alu_src2, 32'h30);
        check("exe_rkd", es_rkd_value, 32'h30);

        // r5 in EXE (0x11) and WB (0x22); rkd = r0 with a MEM producer naming r0
        es_alu_result = 32'h11;
        ws_valid = 1; ws_gr_we = 1; ws_dest = 5'd5; ws_result = 32'h22;
        ms_valid = 1; ms_gr_we = 1; ms_dest = 5'd0; ms_result = 32'h55; ms_data_ok = 1;
        drive_instr(12'h002, 32'h1008, 32'h0, 0, 0, 5'd5, 32'hCCCC, 5'd0, 32'h0, 1, 1, 5'd6, 1, 0);
        step();
        check("prio_exe_src1", alu_src1, 32'h11);
        check("r0_src2", alu_src2, 32'h0);
        check("r0_rkd", es_rkd_value, 32'h0);
        check("op_onehot", {20'b0, alu_op}, 32'h002);

        // MEM beats WB for r7; r8 misses everywhere
        ms_dest = 5'd7; ms_result = 32'h33;
        ws_dest = 5'd7; ws_result = 32'h44;
        drive_instr(12'h800, 32'h100C, 32'h0, 0, 0, 5'd7, 32'h7777, 5'd8, 32'h88, 1, 1, 5'd9, 1, 0);
        step();
        check("prio_ms_src1", alu_src1, 32'h33);
        check("rf_src2", alu_src2, 32'h88);
        check("op_lui", {20'b0, alu_op}, 32'h800);

        // store: src1=pc, src2=imm, store data from regfile
        clear_bypass();
        drive_instr(12'h001, 32'h2000, 32'h123, 1, 1, 5'd1, 32'h1, 5'd3, 32'h99, 0, 1, 5'd0, 0, 0);
        step();
        check("pc_src1", alu_src1, 32'h2000);
        check("imm_src2", alu_src2, 32'h123);
        check("st_rkd", es_rkd_value, 32'h99);

        // ld.w r6, then a consumer of r6
        drive_instr(12'h001, 32'h2004, 32'h4, 0, 1, 5'd1, 32'h100, 5'd0, 32'h0, 1, 0, 5'd6, 1, 1);
        step();
        check("ld_is_load", {31'b0, es_is_load}, 32'h1);
        check("ld_src1", alu_src1, 32'h100);
        es_alu_result = 32'h104;
        drive_instr(12'h001, 32'h2008, 32'h0, 0, 0, 5'd6, 32'h0, 5'd0, 32'h0, 1, 0, 5'd11, 1, 0);
        #1 check("lu_allowin", {31'b0, ds_allowin}, 32'h0);
        step();
        check("lu_bubble", {31'b0, es_valid}, 32'h0);
        ms_valid = 1; ms_gr_we = 1; ms_dest = 5'd6; ms_result = 32'hDEADBEEF; ms_data_ok = 0;
        #1 check("mw_allowin", {31'b0, ds_allowin}, 32'h0);
        step();
        check("mw_bubble", {31'b0, es_valid}, 32'h0);
        ms_data_ok = 1;
        #1 check("mok_allowin", {31'b0, ds_allowin}, 32'h1);
        step();
        check("mok_valid", {31'b0, es_valid}, 32'h1);
        check("mok_src1", alu_src1, 32'hDEADBEEF);

        // MEM back-pressure for three cycles
        clear_bypass();
        ms_allowin = 0;
        drive_instr(12'h004, 32'h200C, 32'h0, 0, 0, 5'd2, 32'h77, 5'd3, 32'h78, 1, 1, 5'd10, 1, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'hDEADBEEF);
            es_alu_result = $urandom_range(0, 32'hFFFF);
            #1 check("bp_allowin", {31'b0, ds_allowin}, 32'h0);
            step();
            check("bp_src1", alu_src1, exp_q.pop_front());
            check("bp_op", {20'b0, alu_op}, 32'h001);
            check("bp_valid", {31'b0, es_valid}, 32'h1);
        end
        ms_allowin = 1;
        #1 check("bp_release", {31'b0, ds_allowin}, 32'h1);
        step();
        check("bp_src1_new", alu_src1, 32'h77);
        check("bp_op_new", {20'b0, alu_op}, 32'h004);

        // flush with a valid decode instruction
        flush = 1;
        drive_instr(12'h008, 32'h3000, 32'h0, 0, 0, 5'd3, 32'h5A, 5'd0, 32'h0, 1, 0, 5'd12, 1, 0);
        step();
        flush = 0;
        check("fl_valid", {31'b0, es_valid}, 32'h0);
        check("fl_src1", alu_src1, 32'h77);
        check("fl_op", {20'b0, alu_op}, 32'h004);

        // reset mid-stream
        step();
        check("rm_valid_pre", {31'b0, es_valid}, 32'h1);
        check("rm_src1_pre", alu_src1, 32'h5A);
        reset = 1;
        step();
        reset = 0;
        check("rm_valid", {31'b0, es_valid}, 32'h0);
        check("rm_src1", alu_src1, 32'h0);
        check("rm_op", {20'b0, alu_op}, 32'h0);

        drive_idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
